// File: rtl/axi_lite_mem_bridge.sv
// AXI4-Lite slave to req/gnt/rvalid memory adapter: joins AW+W, arbitrates fairly
// against AR, decodes out-of-range addresses locally and keeps per-channel response order.

package axi_lite_mem_bridge_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        axi_lite_b_t  b;
        logic         b_valid;
        logic         ar_ready;
        axi_lite_r_t  r;
        logic         r_valid;
    } axi_lite_resp_t;
endpackage

module axi_lite_mem_bridge_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                full;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    always_comb begin
        full     = (count_q == CntWidth'(Depth));
        empty_o  = (count_q == '0);
        data_o   = mem_q[rd_ptr_q];
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CntWidth'(push_i) - CntWidth'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full);
`endif
endmodule

module axi_lite_mem_bridge #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MemBytes  = 4096,
    parameter int unsigned MaxTxns   = 2,
    parameter type lite_req_t  = axi_lite_mem_bridge_pkg::axi_lite_req_t,
    parameter type lite_resp_t = axi_lite_mem_bridge_pkg::axi_lite_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  lite_req_t              slv_req_i,
    output lite_resp_t             slv_resp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(MaxTxns + 1);
    localparam int unsigned RspWidth  = 1 + 2 + DataWidth;
    localparam logic [AddrWidth-1:0] MemLimit  = AddrWidth'(MemBytes);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e                state_q, state_d;
    logic                  lock_sel_q, lock_sel_d;
    logic                  prio_write_q, prio_write_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;

    logic                  write_cand, read_cand, credit_ok;
    logic                  sel_write, cand, in_range;
    logic [AddrWidth-1:0]  sel_addr;
    logic                  mem_accept, err_accept, accept;
    logic                  pend_empty, pend_head_write;
    logic                  rsp_push, rsp_pop, rsp_empty;
    logic [RspWidth-1:0]   rsp_push_data, rsp_head;
    logic                  rsp_is_write;
    logic [1:0]            rsp_resp;
    logic [DataWidth-1:0]  rsp_data;
    logic                  unused_prot;

    assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

    // Candidate selection; a locked request keeps its side until granted.
    always_comb begin
        write_cand = slv_req_i.aw_valid & slv_req_i.w_valid;
        read_cand  = slv_req_i.ar_valid;
        credit_ok  = (cnt_q < CntWidth'(MaxTxns));
        if (state_q == ST_LOCKED) begin
            sel_write = lock_sel_q;
        end else if (write_cand && read_cand) begin
            sel_write = prio_write_q;
        end else begin
            sel_write = write_cand;
        end
        cand       = (state_q == ST_LOCKED) | (credit_ok & (sel_write ? write_cand : read_cand));
        sel_addr   = sel_write ? AddrWidth'(slv_req_i.aw.addr) : AddrWidth'(slv_req_i.ar.addr);
        in_range   = (sel_addr < MemLimit);
        mem_accept = cand & in_range & mem_gnt_i;
        // Errors wait for the memory pipe to drain so they cannot overtake older responses.
        err_accept = cand & ~in_range & pend_empty & ~mem_rvalid_i;
        accept     = mem_accept | err_accept;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            lock_sel_q   <= 1'b0;
            prio_write_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lock_sel_q   <= lock_sel_d;
            prio_write_q <= prio_write_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = (mem_req_o && !mem_gnt_i) ? ST_LOCKED : ST_IDLE;
        lock_sel_d   = sel_write;
        prio_write_d = accept ? ~sel_write : prio_write_q;
        cnt_d        = cnt_q + CntWidth'(accept) - CntWidth'(rsp_pop);
    end

    always_comb begin
        mem_req_o   = cand & in_range;
        mem_we_o    = sel_write;
        mem_addr_o  = sel_addr & AlignMask;
        mem_wdata_o = sel_write ? DataWidth'(slv_req_i.w.data) : '0;
        mem_be_o    = sel_write ? StrbWidth'(slv_req_i.w.strb) : '0;
    end

    axi_lite_mem_bridge_fifo #(
        .Width (1),
        .Depth (MaxTxns)
    ) i_pend_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (mem_accept),
        .data_i  (sel_write),
        .pop_i   (mem_rvalid_i),
        .data_o  (pend_head_write),
        .empty_o (pend_empty)
    );

    always_comb begin
        rsp_push      = mem_rvalid_i | err_accept;
        rsp_push_data = mem_rvalid_i ? {pend_head_write, RespOkay, mem_rdata_i}
                                     : {sel_write, RespDecerr, {DataWidth{1'b0}}};
        rsp_is_write  = rsp_head[RspWidth-1];
        rsp_resp      = rsp_head[DataWidth +: 2];
        rsp_data      = rsp_head[DataWidth-1:0];
        rsp_pop       = ~rsp_empty & (rsp_is_write ? slv_req_i.b_ready : slv_req_i.r_ready);
    end

    axi_lite_mem_bridge_fifo #(
        .Width (RspWidth),
        .Depth (MaxTxns)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_push),
        .data_i  (rsp_push_data),
        .pop_i   (rsp_pop),
        .data_o  (rsp_head),
        .empty_o (rsp_empty)
    );

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = accept & sel_write;
        slv_resp_o.w_ready  = accept & sel_write;
        slv_resp_o.ar_ready = accept & ~sel_write;
        slv_resp_o.b_valid  = ~rsp_empty & rsp_is_write;
        slv_resp_o.b.resp   = rsp_resp;
        slv_resp_o.r_valid  = ~rsp_empty & ~rsp_is_write;
        slv_resp_o.r.data   = rsp_data;
        slv_resp_o.r.resp   = rsp_resp;
    end

`ifndef SYNTHESIS
    a_mem_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o) && $stable(mem_we_o)
                                       && $stable(mem_wdata_o) && $stable(mem_be_o)));
    a_rvalid_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> !pend_empty);
`endif
endmodule
